// File: rtl/soc_event_pkg.sv
// Shared types and constants for the event dispatcher.
package soc_event_pkg;
  localparam int EVNT_NUM_DEFAULT = 256;
  localparam int EVT_ID_W         = $clog2(EVNT_NUM_DEFAULT);

  typedef logic [EVT_ID_W-1:0] evt_id_t;
endpackage

// File: rtl/soc_event_onehot_enc.sv
// Grant vector encoder: lowest set bit index, plus presence and multi-hot flags.
module soc_event_onehot_enc
  import soc_event_pkg::*;
#(
  parameter int N = EVNT_NUM_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_set,
  output logic         multi
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any_set = |vec;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi   = |(vec & (vec - N'(1)));

endmodule

// File: rtl/soc_event_dispatcher.sv
// Queues granted event IDs from the arbiter and hands them to a consumer in order.
module soc_event_dispatcher
  import soc_event_pkg::*;
#(
  parameter int EVNT_NUM   = EVNT_NUM_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [EVNT_NUM-1:0]           grant_i,
  input  logic                          any_grant_i,
  output logic                          grant_ack_o,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [$clog2(EVNT_NUM)-1:0]   evt_id_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_multi_o
);

  localparam int ID_W  = $clog2(EVNT_NUM);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] level;
  logic             err_multi;

  logic [ID_W-1:0]  enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             bad_grant;

  soc_event_onehot_enc #(
    .N (EVNT_NUM),
    .W (ID_W)
  ) u_enc (
    .vec     (grant_i),
    .idx     (enc_idx),
    .any_set (enc_any),
    .multi   (enc_multi)
  );

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  // A full queue refuses the grant even if the head leaves this cycle.
  assign push      = rstn_i & any_grant_i & enc_any & ~full;
  assign pop       = ~empty & evt_ready_i;
  assign bad_grant = any_grant_i & (enc_multi | ~enc_any);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      err_multi <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= enc_idx;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (bad_grant) err_multi <= 1'b1;
    end
  end

  assign grant_ack_o  = push;
  assign evt_valid_o  = ~empty;
  assign evt_id_o     = empty ? '0 : mem[rptr];
  assign fifo_level_o = level;
  assign err_multi_o  = err_multi;

endmodule

// File: tb/tb_soc_event_dispatcher.sv
// Directed and randomized bench for soc_event_dispatcher against a queue-based model.
module tb_soc_event_dispatcher;
  import soc_event_pkg::*;

  localparam int N     = 256;
  localparam int DEPTH = 4;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   grant;
  logic           any_grant;
  logic           grant_ack;
  logic           evt_valid;
  logic           evt_ready;
  evt_id_t        evt_id;
  logic [2:0]     fifo_level;
  logic           err_multi;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  int q[$];
  bit m_err;

  soc_event_dispatcher #(
    .EVNT_NUM   (N),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .grant_i      (grant),
    .any_grant_i  (any_grant),
    .grant_ack_o  (grant_ack),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_id_o     (evt_id),
    .fifo_level_o (fifo_level),
    .err_multi_o  (err_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    else
      pass_cnt++;
  endtask

  function automatic int lowest_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Compares all outputs against the model mid-cycle, then advances both across one edge.
  task automatic step();
    bit exp_ack;
    bit r, a, rd;
    logic [N-1:0] g;
    @(negedge clk);
    r  = rstn;
    a  = any_grant;
    g  = grant;
    rd = evt_ready;
    exp_ack = r && a && (g != '0) && (q.size() < DEPTH);
    check("ack",   64'(grant_ack),  64'(exp_ack));
    check("valid", 64'(evt_valid),  64'(q.size() != 0));
    check("id",    64'(evt_id),     (q.size() != 0) ? 64'(q[0]) : 64'd0);
    check("level", 64'(fifo_level), 64'(q.size()));
    check("err",   64'(err_multi),  64'(m_err));
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (rd && q.size() != 0) void'(q.pop_front());
      if (exp_ack) q.push_back(lowest_bit(g));
      if (a && (g == '0 || $countones(g) > 1)) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic set_grant(input int idx);
    grant = '0;
    grant[idx] = 1'b1;
    any_grant = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; grant = '0; any_grant = 1'b0; evt_ready = 1'b0;
    q.delete(); m_err = 1'b0;
    step(); step();
    check("reset_level", 64'(fifo_level), 64'd0);
    check("reset_valid", 64'(evt_valid), 64'd0);
    check("reset_id",    64'(evt_id), 64'd0);
    rstn = 1'b1;
    step();

    // Single grant, observed the cycle after push, then drains
    set_grant(37); evt_ready = 1'b1; #1;
    check("single_ack", 64'(grant_ack), 64'd1);
    step();
    any_grant = 1'b0; grant = '0; #1;
    check("single_valid", 64'(evt_valid), 64'd1);
    check("single_id",    64'(evt_id), 64'd37);
    step();
    check("single_empty", 64'(evt_valid), 64'd0);

    // Fill to capacity, then pop while full
    evt_ready = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      set_grant(i); #1;
      check("fill_ack", 64'(grant_ack), 64'd1);
      step();
    end
    set_grant(9); #1;
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_noack", 64'(grant_ack), 64'd0);
    step(); step();
    evt_ready = 1'b1; #1;
    check("full_pop_noack", 64'(grant_ack), 64'd0);
    check("full_head", 64'(evt_id), 64'd5);
    step();
    check("after_pop_level", 64'(fifo_level), 64'd3);
    check("after_pop_id", 64'(evt_id), 64'd6);
    check("late_ack9", 64'(grant_ack), 64'd1);
    step();
    any_grant = 1'b0; grant = '0; #1;
    check("pushpop_level", 64'(fifo_level), 64'd3);
    for (int e = 7; e <= 9; e++) begin
      check("drain_id", 64'(evt_id), 64'(e));
      step();
    end
    check("drained", 64'(fifo_level), 64'd0);

    // Multi-hot grant pushes lowest index and latches the error
    evt_ready = 1'b0;
    grant = '0; grant[3] = 1'b1; grant[200] = 1'b1; any_grant = 1'b1; #1;
    check("multi_ack", 64'(grant_ack), 64'd1);
    step();
    any_grant = 1'b0; grant = '0; #1;
    check("multi_id",  64'(evt_id), 64'd3);
    check("multi_err", 64'(err_multi), 64'd1);
    step(); step();
    check("multi_sticky", 64'(err_multi), 64'd1);

    // Reset with three queued entries
    for (int i = 1; i <= 2; i++) begin
      set_grant(i + 10); step();
    end
    any_grant = 1'b0; grant = '0; #1;
    check("pre_reset_level", 64'(fifo_level), 64'd3);
    rstn = 1'b0; set_grant(20); #1;
    check("reset_noack", 64'(grant_ack), 64'd0);
    step();
    rstn = 1'b1; any_grant = 1'b0; grant = '0; #1;
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_err",   64'(err_multi), 64'd0);
    set_grant(255);
    step();
    any_grant = 1'b0; grant = '0; #1;
    check("post_rst_id", 64'(evt_id), 64'd255);
    evt_ready = 1'b1;
    step();

    // Zero grant with any_grant asserted
    evt_ready = 1'b0; any_grant = 1'b1; grant = '0; #1;
    check("zero_ack", 64'(grant_ack), 64'd0);
    step();
    any_grant = 1'b0; #1;
    check("zero_level", 64'(fifo_level), 64'd0);
    check("zero_err",   64'(err_multi), 64'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int kind;
      rstn = ($urandom_range(0, 199) != 0);
      any_grant = ($urandom_range(0, 3) != 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      kind = $urandom_range(0, 9);
      grant = '0;
      if (kind < 7) begin
        grant[$urandom_range(0, N - 1)] = 1'b1;
      end else if (kind < 9) begin
        grant[$urandom_range(0, N - 1)] = 1'b1;
        grant[$urandom_range(0, N - 1)] = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
